sevenseg_fmt: RTL and testbench

SEVENSEG_FMT -- requirements
Module: sevenseg_fmt

---
 rtl/sevenseg_pkg.sv | 29 ++
 rtl/sevenseg_fmt_dabble.sv | 51 +++++
 rtl/sevenseg_fmt.sv | 154 +++++++++++++++
 tb/tb_sevenseg_fmt.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment formatter: extended digit
// code bit positions, the blank/dash codes and the formatter FSM states.
package sevenseg_pkg;

  localparam int BIT_BLANK = 6;
  localparam int BIT_DP    = 5;
  localparam int BIT_DASH  = 4;

  localparam logic [6:0] CODE_BLANK = 7'(1 << BIT_BLANK);
  localparam logic [6:0] CODE_DASH  = 7'(1 << BIT_DASH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FMT
  } state_e;

  function automatic logic [6:0] digit_code(
    input logic [3:0] hex,
    input logic       dp
  );
    logic [6:0] c;
    c         = '0;
    c[3:0]    = hex;
    c[BIT_DP] = dp;
    return c;
  endfunction

endpackage

// File: rtl/sevenseg_fmt_dabble.sv
// bcd_dabble: 16-step shift-add-3 binary to 5-digit BCD converter.
// Ports: clk, rst, start_i, mag_i[15:0], bcd_o[19:0] (digit i at [4i+3:4i]), busy_o.
module bcd_dabble
  import sevenseg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] mag_i,
  output logic [19:0] bcd_o,
  output logic        busy_o
);

  logic [19:0] bcd_q;
  logic [15:0] sh_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [19:0] adj;

  // Correct each BCD nibble before the shift doubles it.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bcd_q  <= '0;
      sh_q   <= mag_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      {bcd_q, sh_q} <= {adj[18:0], sh_q, 1'b0};
      cnt_q         <= cnt_q + 4'd1;
      if (cnt_q == 4'd15)
        busy_q <= 1'b0;
    end
  end

  assign bcd_o  = bcd_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/sevenseg_fmt.sv
// sevenseg_fmt: signed 16-bit value to eight extended 7-seg digit codes,
// with leading-zero blanking, sign dash, decimal point and optional scan.
// Ports: clk, rst, in_valid/in_ready, value, dp_en, dp_pos -> digits[55:0],
// done pulse, an_n[7:0], d_scan[6:0]. Scan built only with SEVENSEG_SCAN_EN.
module sevenseg_fmt
  import sevenseg_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] value,
  input  logic        dp_en,
  input  logic [2:0]  dp_pos,
  output logic [55:0] digits,
  output logic        done,
  output logic [7:0]  an_n,
  output logic [6:0]  d_scan
);

  if (SCAN_DIV < 1) begin : g_div_chk
    $error("SCAN_DIV must be at least 1");
  end

  state_e          state_q;
  logic            rdy_q;
  logic            done_q;
  logic [3:0]      cnt_q;
  logic            sign_q;
  logic            dp_en_q;
  logic [2:0]      dp_pos_q;
  logic [7:0][6:0] digits_q;
  logic [7:0][6:0] fmt_d;

  logic            accept;
  logic [15:0]     mag;
  logic [19:0]     dab_bcd;
  logic            dab_busy;
  logic [7:0][3:0] nib;
  logic [2:0]      msd;
  logic [2:0]      keep;
  logic [2:0]      dash_at;

  assign accept = in_valid && rdy_q;
  // Two's-complement negate: -32768 maps to 16'h8000 = 32768.
  assign mag    = value[15] ? 16'(-value) : value;

  bcd_dabble u_dabble (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .mag_i   (mag),
    .bcd_o   (dab_bcd),
    .busy_o  (dab_busy)
  );

  assign nib = {12'd0, dab_bcd};

  // Rightmost digits up to 'keep' are shown; anything left of it blanks.
  always_comb begin
    msd = '0;
    for (int i = 0; i < 5; i++) begin
      if (nib[i] != 4'd0)
        msd = 3'(i);
    end
    keep = (dp_en_q && dp_pos_q > msd) ? dp_pos_q : msd;
    dash_at = (keep == 3'd7) ? keep : keep + 3'd1;
    for (int i = 0; i < 8; i++) begin
      if (i > int'(keep))
        fmt_d[i] = CODE_BLANK;
      else
        fmt_d[i] = digit_code(nib[i],
                              dp_en_q && dp_pos_q == 3'(i));
    end
    if (sign_q)
      fmt_d[dash_at] = CODE_DASH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      dp_en_q  <= 1'b0;
      dp_pos_q <= '0;
      digits_q <= {8{CODE_BLANK}};
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            sign_q   <= value[15];
            dp_en_q  <= dp_en;
            dp_pos_q <= dp_pos;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            state_q  <= S_CONV;
          end
        end
        S_CONV: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15)
            state_q <= S_FMT;
        end
        S_FMT: begin
          if (!dab_busy) begin
            digits_q <= fmt_d;
            done_q   <= 1'b1;
            rdy_q    <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = rdy_q;
  assign done     = done_q;
  assign digits   = digits_q;

`ifdef SEVENSEG_SCAN_EN
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] sc_q;
  logic [2:0]    idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q  <= '0;
      idx_q <= '0;
    end else if (sc_q == CW'(SCAN_DIV - 1)) begin
      sc_q  <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      sc_q <= sc_q + 1'b1;
    end
  end

  assign an_n   = ~(8'b1 << idx_q);
  assign d_scan = digits_q[idx_q];
`else
  assign an_n   = 8'hFF;
  assign d_scan = CODE_BLANK;
`endif

endmodule

// File: tb/tb_sevenseg_fmt.sv
// Scoreboard bench for sevenseg_fmt: random and directed values against
// a decimal-arithmetic reference model; monitor checks every cycle.
module tb_sevenseg_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic        dp_en;
  logic [2:0]  dp_pos;
  logic [55:0] digits;
  logic        done;
  logic [7:0]  an_n;
  logic [6:0]  d_scan;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [55:0] exp_q[$];
  int          t_q[$];

  localparam logic [55:0] ALL_BLANK = {8{7'b1000000}};

  sevenseg_fmt #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .dp_en    (dp_en),
    .dp_pos   (dp_pos),
    .digits   (digits),
    .done     (done),
    .an_n     (an_n),
    .d_scan   (d_scan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits by division, then display rules.
  function automatic logic [55:0] model(int v, bit en, int pos);
    int m, p, top, keep, dash;
    int d[8];
    logic [6:0] c;
    logic [55:0] r;
    m = (v < 0) ? -v : v;
    p = 1;
    top = 0;
    for (int k = 0; k < 8; k++) begin
      d[k] = (m / p) % 10;
      p = p * 10;
      if (d[k] != 0) top = k;
    end
    keep = (en && pos > top) ? pos : top;
    for (int k = 0; k < 8; k++) begin
      if (k > keep) c = 7'b1000000;
      else begin
        c = 7'(d[k]);
        if (en && pos == k) c = c | 7'b0100000;
      end
      r[k*7 +: 7] = c;
    end
    if (v < 0) begin
      dash = (keep == 7) ? 7 : keep + 1;
      r[dash*7 +: 7] = 7'b0010000;
    end
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      failures++;
      $display("FAIL ready_timeout in_ready=%0b required=1",
               in_ready);
    end
  endtask

  task automatic send(int v, bit en, int pos, bit glitch);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    value    = 16'(v);
    dp_en    = en;
    dp_pos   = 3'(pos);
    in_valid = 1'b1;
    exp_q.push_back(model(v, en, pos));
    @(posedge clk);
    #1;
    t_q.push_back(cyc);
    in_valid = 1'b0;
    if (glitch) begin
      repeat (3) @(negedge clk);
      value    = 16'($urandom);
      dp_en    = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Monitor: pops expectations on done, checks hold and scan each cycle.
  initial begin
    logic [55:0] last;
    logic [55:0] e;
    int t, sk, idx;
    last = ALL_BLANK;
    sk = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sk = 0;
        last = ALL_BLANK;
        checks++;
        if (digits !== ALL_BLANK || done !== 1'b0
            || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL reset_state digits=%h done=%b rdy=%b required %h 0 1",
                   digits, done, in_ready, ALL_BLANK);
        end
      end else begin
        sk++;
        if (done === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL spurious_done digits=%h required no done",
                     digits);
          end else begin
            e = exp_q.pop_front();
            t = t_q.pop_front();
            if (digits !== e) begin
              failures++;
              $display("FAIL digits got=%h required=%h", digits, e);
            end
            checks++;
            if (cyc != t + 17) begin
              failures++;
              $display("FAIL latency got=%0d required=17", cyc - t);
            end
          end
          last = digits;
        end else begin
          checks++;
          if (digits !== last) begin
            failures++;
            $display("FAIL hold got=%h required=%h", digits, last);
          end
        end
      end
      checks++;
`ifdef SEVENSEG_SCAN_EN
      idx = (sk / 4) % 8;
      if (an_n !== ~(8'b1 << idx)
          || d_scan !== digits[idx*7 +: 7]) begin
        failures++;
        $display("FAIL scan an_n=%h d_scan=%b idx_required=%0d",
                 an_n, d_scan, idx);
      end
`else
      idx = 0;
      if (an_n !== 8'hFF || d_scan !== 7'b1000000) begin
        failures++;
        $display("FAIL scan_off an_n=%h d_scan=%b required ff 1000000",
                 an_n, d_scan);
      end
`endif
    end
  end

  initial begin
    bit ok;
    int v;
    rst      = 1'b1;
    in_valid = 1'b0;
    value    = '0;
    dp_en    = 1'b0;
    dp_pos   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    send(1234, 0, 0, 0);
    send(-32768, 0, 0, 1);
    send(5, 1, 2, 0);
    send(-1, 1, 7, 1);
    send(32767, 1, 0, 0);
    send(0, 1, 4, 0);

    // Abort a conversion on its 8th cycle; no done may follow.
    wait_ready(ok);
    value    = 16'd1234;
    dp_en    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready got=%b required=1", in_ready);
    end
    send(0, 0, 0, 1);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        v = int'($urandom_range(0, 999));
        if ($urandom_range(0, 1) == 1) v = -v;
      end else begin
        v = int'(shortint'($urandom));
      end
      send(v, 1'($urandom), int'($urandom_range(0, 7)),
           1'($urandom));
    end

    for (int n = 0; n < 40 && exp_q.size() != 0; n++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
